five_number_adder_arbiter: RTL and testbench

Sequencing and arbitration controller for the 8-bit signed saturating five-operand adder datapath. Two requesters each stream a 5-beat operand packet over valid/ready. The block grants one requester per packet by round-robin or fixed priority. It collects the five operands into a local buffer and computes the saturated signed sum. It returns the result, with requester ID and saturation flag, over a valid/ready output port.

---
 rtl/five_number_adder_arbiter.sv | 173 +++++++++++++++++
 tb/tb_five_number_adder_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/five_number_adder_arbiter.sv
// five_number_adder_arbiter
//   Arbitrates two requesters that each stream a 5-beat signed operand
//   packet, buffers the granted packet, computes the saturated signed sum
//   and returns it with the owner ID and a clamp flag.
//
// Ports
//   clk, rst_n               : rising-edge clock, synchronous active-low reset
//   req0_valid/data/ready    : requester 0 operand stream (8-bit two's complement)
//   req1_valid/data/ready    : requester 1 operand stream (8-bit two's complement)
//   out_valid/sum/id/sat     : result stream (sum, owner, clamp flag)
//   out_ready                : downstream accepts the result
//   busy                     : high whenever the controller is not idle
//
// Parameters
//   RR_EN : 1 = round-robin on ties, 0 = requester 0 always wins ties

module five_number_adder_arbiter #(
    parameter logic RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,

    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,

    output logic       out_valid,
    output logic [7:0] out_sum,
    output logic       out_id,
    output logic       out_sat,
    input  logic       out_ready,

    output logic       busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       gnt_q, gnt_d;
    logic       last_gnt_q, last_gnt_d;
    logic [7:0] slot_q [5];
    logic [7:0] slot_d [5];
    logic [7:0] out_sum_q, out_sum_d;
    logic       out_id_q, out_id_d;
    logic       out_sat_q, out_sat_d;

    logic        in_load;
    logic        beat_valid;
    logic [7:0]  beat_data;
    logic        arb_winner;
    logic [10:0] sum_full;
    logic        sat_hi;
    logic        sat_lo;
    logic [7:0]  sat_sum;

    function automatic logic [10:0] sext(input logic [7:0] v);
        return {{3{v[7]}}, v};
    endfunction

    // Readies depend only on registered state and grant.
    assign in_load    = (state_q == S_LOAD);
    assign req0_ready = in_load && !gnt_q;
    assign req1_ready = in_load &&  gnt_q;

    assign beat_valid = gnt_q ? req1_valid : req0_valid;
    assign beat_data  = gnt_q ? req1_data  : req0_data;

    // A lone requester always wins; ties go to !last_gnt or to requester 0.
    always_comb begin
        if (req0_valid && req1_valid) begin
            arb_winner = RR_EN ? !last_gnt_q : 1'b0;
        end else begin
            arb_winner = req1_valid;
        end
    end

    // Five 8-bit operands span [-640, 635], so an 11-bit sum is exact.
    assign sum_full = sext(slot_q[0]) + sext(slot_q[1]) + sext(slot_q[2])
                    + sext(slot_q[3]) + sext(slot_q[4]);

    // Out of 8-bit range exactly when bits [10:7] are not all equal.
    assign sat_hi  = !sum_full[10] && (sum_full[9:7] != 3'b000);
    assign sat_lo  =  sum_full[10] && (sum_full[9:7] != 3'b111);
    assign sat_sum = sat_hi ? 8'h7F : (sat_lo ? 8'h80 : sum_full[7:0]);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        slot_d     = slot_q;
        out_sum_d  = out_sum_q;
        out_id_d   = out_id_q;
        out_sat_d  = out_sat_q;

        case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    gnt_d   = arb_winner;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (beat_valid) begin
                    for (int unsigned i = 0; i < 5; i++) begin
                        if (cnt_q == 3'(i)) begin
                            slot_d[i] = beat_data;
                        end
                    end
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd4) begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                out_sum_d = sat_sum;
                out_id_d  = gnt_q;
                out_sat_d = sat_hi || sat_lo;
                state_d   = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    last_gnt_d = gnt_q;
                    cnt_d      = '0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            gnt_q      <= 1'b0;
            // Starting at 1 makes requester 0 win the first tie.
            last_gnt_q <= 1'b1;
            slot_q     <= '{default: '0};
            out_sum_q  <= '0;
            out_id_q   <= 1'b0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            slot_q     <= slot_d;
            out_sum_q  <= out_sum_d;
            out_id_q   <= out_id_d;
            out_sat_q  <= out_sat_d;
        end
    end

    assign out_valid = (state_q == S_OUT);
    assign out_sum   = out_sum_q;
    assign out_id    = out_id_q;
    assign out_sat   = out_sat_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_five_number_adder_arbiter.sv
// Testbench for five_number_adder_arbiter: a round-robin instance (index 0)
// and a fixed-priority instance (index 1) share clock and reset; each has
// its own requester drivers and a result scoreboard.

module tb_five_number_adder_arbiter;

    typedef struct packed {
        logic [7:0] sum;
        logic       id;
        logic       sat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rv [2][2];
    logic [7:0]  rd [2][2];
    logic [1:0]  rr0, rr1;
    logic [1:0]  ov, oid, osat, bsy, orr;
    logic [15:0] osum;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;

    exp_t q_rr[$];
    exp_t q_fp[$];
    exp_t e_rr, e_fp;

    int unsigned c0, t_rdy, t_ov, n_w;
    logic        busy_after;
    logic [39:0] p, pa, pb, pbp, pr0, pr1;
    logic [39:0] sat_p [5];

    five_number_adder_arbiter #(.RR_EN(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(rv[0][0]), .req0_data(rd[0][0]), .req0_ready(rr0[0]),
        .req1_valid(rv[0][1]), .req1_data(rd[0][1]), .req1_ready(rr1[0]),
        .out_valid(ov[0]), .out_sum(osum[7:0]), .out_id(oid[0]), .out_sat(osat[0]),
        .out_ready(orr[0]), .busy(bsy[0])
    );

    five_number_adder_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(rv[1][0]), .req0_data(rd[1][0]), .req0_ready(rr0[1]),
        .req1_valid(rv[1][1]), .req1_data(rd[1][1]), .req1_ready(rr1[1]),
        .out_valid(ov[1]), .out_sum(osum[15:8]), .out_id(oid[1]), .out_sat(osat[1]),
        .out_ready(orr[1]), .busy(bsy[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] pk(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d,
                                       input logic [7:0] e);
        return {e, d, c, b, a};
    endfunction

    // Reference: exact integer sum, then clamp to [-128, 127].
    function automatic exp_t model(input logic [39:0] pkt, input logic id);
        int   s;
        exp_t r;
        s = 0;
        for (int i = 0; i < 5; i++) s += int'($signed(pkt[i*8 +: 8]));
        r.id = id;
        if (s > 127) begin
            r.sum = 8'h7F; r.sat = 1'b1;
        end else if (s < -128) begin
            r.sum = 8'h80; r.sat = 1'b1;
        end else begin
            r.sum = s[7:0]; r.sat = 1'b0;
        end
        return r;
    endfunction

    function automatic logic rdy(input int k, input int r);
        return (r != 0) ? rr1[k] : rr0[k];
    endfunction

    // Scoreboards: compare each result at the negedge before its handshake.
    always @(negedge clk) begin
        if (rst_n && ov[0] && orr[0]) begin
            if (q_rr.size() == 0) begin
                check_eq("rr_unexpected_result", 32'(q_rr.size()), 1);
            end else begin
                e_rr = q_rr.pop_front();
                check_eq("rr_sum", osum[7:0], e_rr.sum);
                check_eq("rr_id",  oid[0],    e_rr.id);
                check_eq("rr_sat", osat[0],   e_rr.sat);
            end
        end
        if (rst_n && ov[1] && orr[1]) begin
            if (q_fp.size() == 0) begin
                check_eq("fp_unexpected_result", 32'(q_fp.size()), 1);
            end else begin
                e_fp = q_fp.pop_front();
                check_eq("fp_sum", osum[15:8], e_fp.sum);
                check_eq("fp_id",  oid[1],     e_fp.id);
                check_eq("fp_sat", osat[1],    e_fp.sat);
            end
        end
    end

    task automatic send_beat(input int k, input int r, input logic [7:0] d);
        int unsigned n;
        rv[k][r] = 1'b1;
        rd[k][r] = d;
        n = 0;
        @(negedge clk);
        while (!rdy(k, r) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rdy(k, r)) check_eq("beat_timeout", 32'(rdy(k, r)), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int k, input int r, input logic [39:0] pkt,
                            input int stall_after, input int stall_len);
        for (int b = 0; b < 5; b++) begin
            send_beat(k, r, pkt[b*8 +: 8]);
            if (b == stall_after) begin
                // Garbage data while invalid exposes any phantom acceptance.
                rv[k][r] = 1'b0;
                rd[k][r] = 8'h7F;
                repeat (stall_len) @(posedge clk);
                #1;
            end
        end
        rv[k][r] = 1'b0;
    endtask

    task automatic wait_drain(input int k);
        int unsigned n;
        n = 0;
        if (k == 0) begin
            while (q_rr.size() != 0 && n < 300) begin @(negedge clk); n++; end
            check_eq("rr_drain", 32'(q_rr.size()), 0);
        end else begin
            while (q_fp.size() != 0 && n < 300) begin @(negedge clk); n++; end
            check_eq("fp_drain", 32'(q_fp.size()), 0);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req0_ready"}, rr0[0],    0);
        check_eq({tag, "_req1_ready"}, rr1[0],    0);
        check_eq({tag, "_out_valid"},  ov[0],     0);
        check_eq({tag, "_out_sum"},    osum[7:0], 0);
        check_eq({tag, "_out_id"},     oid[0],    0);
        check_eq({tag, "_out_sat"},    osat[0],   0);
        check_eq({tag, "_busy"},       bsy[0],    0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached limit 200000 without finishing", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        orr   = 2'b11;
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 2; r++) begin
                rv[k][r] = 1'b0;
                rd[k][r] = 8'h00;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        check_eq("rst_fp_busy", bsy[1], 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single packet with latency and return-to-idle timing.
        p = pk(8'd10, 8'd15, 8'd20, 8'd25, 8'd30);
        q_rr.push_back(model(p, 1'b0));
        c0 = cyc; t_rdy = 0; t_ov = 0;
        fork
            send_pkt(0, 0, p, -1, 0);
            begin
                n_w = 0;
                while (!ov[0] && n_w < 100) begin
                    @(negedge clk);
                    if (rr0[0] && t_rdy == 0) t_rdy = cyc;
                    n_w++;
                end
                t_ov = cyc;
                @(negedge clk);
                busy_after = bsy[0];
            end
        join
        check_eq("lat_ready",     t_rdy - c0, 1);
        check_eq("lat_out_valid", t_ov - c0,  7);
        check_eq("busy_after_handshake", busy_after, 0);
        wait_drain(0);

        // Saturation boundaries on requester 1.
        sat_p[0] = pk(8'h64, 8'h64, 8'h64, 8'h64, 8'h64);
        sat_p[1] = pk(8'h9C, 8'h9C, 8'h9C, 8'h9C, 8'h9C);
        sat_p[2] = pk(8'h7F, 8'h00, 8'h00, 8'h00, 8'h00);
        sat_p[3] = pk(8'h80, 8'h00, 8'h00, 8'h00, 8'h00);
        sat_p[4] = pk(8'h7F, 8'h01, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) q_rr.push_back(model(sat_p[i], 1'b1));
        for (int i = 0; i < 5; i++) send_pkt(0, 1, sat_p[i], -1, 0);
        wait_drain(0);

        // Round-robin with both requesters continuously valid.
        pa = pk(8'hF6, 8'hF1, 8'hEC, 8'hE7, 8'hE2);
        pb = pk(8'h7F, 8'h7F, 8'h80, 8'h80, 8'h00);
        q_rr.push_back(model(pa, 1'b0));
        q_rr.push_back(model(pb, 1'b1));
        q_rr.push_back(model(pa, 1'b0));
        q_rr.push_back(model(pb, 1'b1));
        fork
            begin send_pkt(0, 0, pa, -1, 0); send_pkt(0, 0, pa, -1, 0); end
            begin send_pkt(0, 1, pb, -1, 0); send_pkt(0, 1, pb, -1, 0); end
        join
        wait_drain(0);

        // Fixed priority: requester 1 is served only after requester 0 goes quiet.
        for (int i = 0; i < 3; i++) q_fp.push_back(model(pa, 1'b0));
        q_fp.push_back(model(pb, 1'b1));
        fork
            begin
                for (int i = 0; i < 3; i++) send_pkt(1, 0, pa, -1, 0);
            end
            send_pkt(1, 1, pb, -1, 0);
        join
        wait_drain(1);

        // Input stall plus output backpressure with a competing requester.
        pbp = pk(8'h32, 8'hEC, 8'h1E, 8'hF1, 8'h05);
        q_rr.push_back(model(pbp, 1'b0));
        orr[0] = 1'b0;
        fork
            send_pkt(0, 0, pbp, 1, 3);
            begin
                n_w = 0;
                while (!ov[0] && n_w < 200) begin @(negedge clk); n_w++; end
                check_eq("bp_out_valid_seen", ov[0], 1);
                rv[0][1] = 1'b1;
                rd[0][1] = 8'h11;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check_eq("bp_hold_valid", ov[0],     1);
                    check_eq("bp_hold_sum",   osum[7:0], 8'h32);
                    check_eq("bp_hold_rdy0",  rr0[0],    0);
                    check_eq("bp_hold_rdy1",  rr1[0],    0);
                    check_eq("bp_hold_busy",  bsy[0],    1);
                end
                @(posedge clk);
                #1;
                orr[0]   = 1'b1;
                rv[0][1] = 1'b0;
            end
        join
        wait_drain(0);

        // Reset after three accepted beats discards the partial packet.
        send_beat(0, 0, 8'h40);
        send_beat(0, 0, 8'h40);
        send_beat(0, 0, 8'h40);
        rv[0][0] = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // A tie right after reset must go to requester 0.
        pr0 = pk(8'hFB, 8'h03, 8'h00, 8'h00, 8'h00);
        pr1 = pk(8'h01, 8'h01, 8'h01, 8'h01, 8'h01);
        q_rr.push_back(model(pr0, 1'b0));
        q_rr.push_back(model(pr1, 1'b1));
        fork
            send_pkt(0, 0, pr0, -1, 0);
            send_pkt(0, 1, pr1, -1, 0);
        join
        wait_drain(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
